// File: rtl/abs_delta_decoder_o6_if.sv
// Stream bundle between the abs-diff link, the delta decoder and
// the error-evaluation datapath: input delta beats and output samples.
interface abs_delta_decoder_o6_if #(
    parameter int W = 6
);
    logic         s_valid;
    logic         s_ready;
    logic         s_sync;
    logic         s_sign;
    logic [W-1:0] s_mag;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_clip;

    modport master (
        output s_valid, s_sync, s_sign, s_mag, m_ready,
        input  s_ready, m_valid, m_data, m_clip
    );

    modport slave (
        input  s_valid, s_sync, s_sign, s_mag, m_ready,
        output s_ready, m_valid, m_data, m_clip
    );
endinterface

// File: rtl/abs_delta_decoder_o6.sv
// Sign-magnitude delta decoder: new = prev +/- mag, one output register.
// Optional macro ABS_DELTA_SAT_EN: clamp out-of-range sums instead of wrapping.
module abs_delta_decoder_o6 #(
    parameter int W     = 6,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    abs_delta_decoder_o6_if.slave bus,
    output logic [CNT_W-1:0]    smp_cnt,
    output logic [CNT_W-1:0]    clip_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e           state_q;
    logic [W-1:0]     prev_q;
    logic             m_valid_q;
    logic [W-1:0]     m_data_q;
    logic             m_clip_q;
    logic [CNT_W-1:0] smp_cnt_q;
    logic [CNT_W-1:0] clip_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    logic             s_ready_d;
    logic             acc_d;
    logic             xfer_d;
    logic [W:0]       sum_d;
    logic             ovf_d;
    logic [W-1:0]     res_d;

    // Handshake qualifiers: accept when the output slot is free or draining.
    always_comb begin
        s_ready_d = ~m_valid_q | bus.m_ready;
        acc_d     = bus.s_valid & s_ready_d;
        xfer_d    = m_valid_q & bus.m_ready;
    end

    // Delta arithmetic in W+1 bits; bit W is carry on add, borrow on subtract.
    always_comb begin
        if (bus.s_sign) begin
            sum_d = {1'b0, prev_q} - {1'b0, bus.s_mag};
        end else begin
            sum_d = {1'b0, prev_q} + {1'b0, bus.s_mag};
        end
        ovf_d = sum_d[W];
`ifdef ABS_DELTA_SAT_EN
        if (ovf_d) begin
            res_d = bus.s_sign ? '0 : '1;
        end else begin
            res_d = sum_d[W-1:0];
        end
`else
        res_d = sum_d[W-1:0];
`endif
    end

    // FSM, reference sample, output register and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_clip_q   <= 1'b0;
            smp_cnt_q  <= '0;
            clip_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (xfer_d) begin
                m_valid_q <= 1'b0;
                if (smp_cnt_q != '1) begin
                    smp_cnt_q <= smp_cnt_q + 1'b1;
                end
            end
            if (acc_d) begin
                if (bus.s_sync) begin
                    state_q   <= RUN;
                    prev_q    <= bus.s_mag;
                    m_valid_q <= 1'b1;
                    m_data_q  <= bus.s_mag;
                    m_clip_q  <= 1'b0;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (drop_cnt_q != '1) begin
                                drop_cnt_q <= drop_cnt_q + 1'b1;
                            end
                        end
                        RUN: begin
                            prev_q    <= res_d;
                            m_valid_q <= 1'b1;
                            m_data_q  <= res_d;
                            m_clip_q  <= ovf_d;
                            if (ovf_d && clip_cnt_q != '1) begin
                                clip_cnt_q <= clip_cnt_q + 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.s_ready = s_ready_d;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_clip  = m_clip_q;
    assign smp_cnt     = smp_cnt_q;
    assign clip_cnt    = clip_cnt_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_abs_delta_decoder_o6.sv
// Directed bench for abs_delta_decoder_o6; expectations follow the
// ABS_DELTA_SAT_EN setting of the build.
module tb_abs_delta_decoder_o6;

    localparam int W     = 6;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] clip_cnt;
    logic [CNT_W-1:0] drop_cnt;
    int               n_vec;
    int               n_err;

    abs_delta_decoder_o6_if #(.W(W)) bus ();

    abs_delta_decoder_o6 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .smp_cnt  (smp_cnt),
        .clip_cnt (clip_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat, wait (bounded) for s_ready, step past the edge.
    task automatic send(input logic sync, input logic sign,
                        input logic [W-1:0] mag);
        int n;
        bus.s_valid = 1'b1;
        bus.s_sync  = sync;
        bus.s_sign  = sign;
        bus.s_mag   = mag;
        n = 0;
        #0;
        while (!bus.s_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.s_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout s_ready=%0b required 1", bus.s_ready);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [W-1:0] d,
                           input logic c);
        n_vec++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== d || bus.m_clip !== c) begin
            n_err++;
            $display("FAIL %s got v=%0b d=%0d c=%0b required v=1 d=%0d c=%0b",
                     nm, bus.m_valid, bus.m_data, bus.m_clip, d, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_sync  = 1'b0;
        bus.s_sign  = 1'b0;
        bus.s_mag   = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_clip !== 1'b0 ||
            smp_cnt !== '0 || clip_cnt !== '0 || drop_cnt !== '0 ||
            bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset v=%0b d=%0d c=%0b cnt=%0d/%0d/%0d rdy=%0b required zeros rdy=1",
                     bus.m_valid, bus.m_data, bus.m_clip, smp_cnt, clip_cnt,
                     drop_cnt, bus.s_ready);
        end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_drop();
        send(1'b0, 1'b0, 6'd5);
        n_vec++;
        if (bus.m_valid !== 1'b0 || drop_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL drop v=%0b drop_cnt=%0d required v=0 drop_cnt=1",
                     bus.m_valid, drop_cnt);
        end
    endtask

    task automatic test_chain();
        send(1'b1, 1'b0, 6'd20);
        chk_out("chain_sync20", 6'd20, 1'b0);
        send(1'b0, 1'b0, 6'd7);
        chk_out("chain_plus7", 6'd27, 1'b0);
        send(1'b0, 1'b1, 6'd12);
        chk_out("chain_minus12", 6'd15, 1'b0);
        idle_cycle();
        n_vec++;
        if (smp_cnt !== 16'd3 || bus.m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL chain_smp smp_cnt=%0d v=%0b required 3 v=0",
                     smp_cnt, bus.m_valid);
        end
    endtask

    task automatic test_overflow();
        send(1'b1, 1'b0, 6'd60);
        chk_out("ovf_sync60", 6'd60, 1'b0);
        send(1'b0, 1'b0, 6'd9);
`ifdef ABS_DELTA_SAT_EN
        chk_out("ovf_plus9", 6'd63, 1'b1);
`else
        chk_out("ovf_plus9", 6'd5, 1'b1);
`endif
        idle_cycle();
        n_vec++;
        if (clip_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL ovf_clip_cnt got %0d required 1", clip_cnt);
        end
    endtask

    task automatic test_underflow();
        send(1'b1, 1'b0, 6'd3);
        chk_out("unf_sync3", 6'd3, 1'b0);
        send(1'b0, 1'b1, 6'd10);
`ifdef ABS_DELTA_SAT_EN
        chk_out("unf_minus10", 6'd0, 1'b1);
        send(1'b0, 1'b1, 6'd0);
        chk_out("unf_zero_mag", 6'd0, 1'b0);
`else
        chk_out("unf_minus10", 6'd57, 1'b1);
        send(1'b0, 1'b1, 6'd0);
        chk_out("unf_zero_mag", 6'd57, 1'b0);
`endif
        idle_cycle();
        n_vec++;
        if (clip_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL unf_clip_cnt got %0d required 2", clip_cnt);
        end
    endtask

    task automatic test_boundary();
        send(1'b1, 1'b1, 6'd63);
        chk_out("bnd_sync63_sign", 6'd63, 1'b0);
        send(1'b0, 1'b0, 6'd0);
        chk_out("bnd_63_plus0", 6'd63, 1'b0);
        send(1'b0, 1'b1, 6'd63);
        chk_out("bnd_63_minus63", 6'd0, 1'b0);
        send(1'b0, 1'b0, 6'd63);
        chk_out("bnd_0_plus63", 6'd63, 1'b0);
        send(1'b0, 1'b0, 6'd1);
`ifdef ABS_DELTA_SAT_EN
        chk_out("bnd_63_plus1", 6'd63, 1'b1);
`else
        chk_out("bnd_63_plus1", 6'd0, 1'b1);
`endif
        send(1'b1, 1'b0, 6'd0);
        chk_out("bnd_sync0", 6'd0, 1'b0);
        idle_cycle();
        n_vec++;
        if (smp_cnt !== 16'd14 || clip_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL bnd_counts smp=%0d clip=%0d required 14 3",
                     smp_cnt, clip_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bus.m_ready = 1'b0;
        send(1'b1, 1'b0, 6'd10);
        bus.s_valid = 1'b1;
        bus.s_sync  = 1'b0;
        bus.s_sign  = 1'b0;
        bus.s_mag   = 6'd1;
        for (int i = 0; i < 4; i++) begin
            #0;
            n_vec++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== 6'd10 ||
                bus.s_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%0d v=%0b d=%0d rdy=%0b required v=1 d=10 rdy=0",
                         i, bus.m_valid, bus.m_data, bus.s_ready);
            end
            idle_cycle();
        end
        bus.m_ready = 1'b1;
        #1;
        n_vec++;
        if (bus.s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_rdy got %0b required 1", bus.s_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            idle_cycle();
            if (k == 4) bus.s_valid = 1'b0;
            chk_out($sformatf("stream_%0d", k), 6'(10 + k), 1'b0);
        end
        idle_cycle();
        n_vec++;
        if (bus.m_valid !== 1'b0 || smp_cnt !== 16'd19) begin
            n_err++;
            $display("FAIL stream_end v=%0b smp=%0d required v=0 smp=19",
                     bus.m_valid, smp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bus.m_ready = 1'b0;
        send(1'b1, 1'b0, 6'd30);
        chk_out("mid_pending", 6'd30, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.m_clip !== 1'b0 ||
            smp_cnt !== '0 || clip_cnt !== '0 || drop_cnt !== '0) begin
            n_err++;
            $display("FAIL mid_reset v=%0b d=%0d c=%0b cnt=%0d/%0d/%0d required zeros",
                     bus.m_valid, bus.m_data, bus.m_clip, smp_cnt, clip_cnt,
                     drop_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.m_ready = 1'b1;
        send(1'b0, 1'b0, 6'd5);
        n_vec++;
        if (bus.m_valid !== 1'b0 || drop_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL mid_drop v=%0b drop=%0d required v=0 drop=1",
                     bus.m_valid, drop_cnt);
        end
        send(1'b1, 1'b0, 6'd42);
        chk_out("mid_sync42", 6'd42, 1'b0);
        idle_cycle();
        n_vec++;
        if (smp_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL mid_smp got %0d required 1", smp_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_drop();
        test_chain();
        test_overflow();
        test_underflow();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
